// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader_if
//  Purpose  : Control, register-file read port and word-stream bundle of the
//             register dump reader.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   dump_len;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] dout_data;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;
  logic              done;

  // master: the dump engine
  modport master (
    input  start, abort, base_addr, dump_len, rf_data, dout_ready,
    output rf_addr, dout_data, dout_valid, dout_last, busy, done
  );

  // slave: register file plus debug host
  modport slave (
    output start, abort, base_addr, dump_len, rf_data, dout_ready,
    input  rf_addr, dout_data, dout_valid, dout_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader
//  Purpose  : Walks a read address over a register-file block and streams each
//             captured word on a valid/ready port. Optional macro CHECKSUM_EN
//             appends an XOR checksum word after the register words.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_REGS = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  reg_dump_reader_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   C_NREGS     = (ADDR_W+1)'(N_REGS);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(N_REGS - 1);
  localparam logic [ADDR_W:0]   C_ONE       = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic [ADDR_W:0]   w_len_clip;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_len_clip  = (io_bus.dump_len > C_NREGS) ? C_NREGS : io_bus.dump_len;
  assign w_addr_next = (r_addr == C_LAST_ADDR) ? '0 : r_addr + 1'b1;

  // The latched walk address drives the read port directly, so it only moves
  // when a new word is about to be fetched.
  assign io_bus.rf_addr    = r_addr;
  assign io_bus.dout_data  = r_data;
  assign io_bus.dout_valid = r_valid;
  assign io_bus.dout_last  = r_last;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else if (io_bus.abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_busy <= 1'b1;
            if (io_bus.dump_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= io_bus.base_addr;
              r_rem   <= w_len_clip;
`ifdef CHECKSUM_EN
              r_csum  <= '0;
`endif
              r_state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          r_data  <= io_bus.rf_data;
          r_valid <= 1'b1;
`ifdef CHECKSUM_EN
          r_last  <= 1'b0;
`else
          r_last  <= (r_rem == C_ONE);
`endif
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (r_valid && io_bus.dout_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum  <= r_csum ^ r_data;
`endif
            if (r_rem == C_ONE) begin
`ifdef CHECKSUM_EN
              // Checksum word is presented straight away, including this word.
              r_data  <= r_csum ^ r_data;
              r_valid <= 1'b1;
              r_last  <= 1'b1;
              r_state <= S_CSUM;
`else
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_addr  <= w_addr_next;
              r_rem   <= r_rem - C_ONE;
              r_state <= S_FETCH;
            end
          end
        end

`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (r_valid && io_bus.dout_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_reader
//  Purpose  : Directed, table-driven self-checking bench for reg_dump_reader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

  logic clk;
  logic rst_n;
  logic [31:0] rf_mem [32];

  reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5), .N_REGS(32)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  assign bus.rf_data = rf_mem[bus.rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  base;
    logic [5:0]  len;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
    int          exp_done_cyc;
  } vec_t;

  logic [31:0] words [$];
  logic        lasts [$];
  logic [4:0]  addrs [$];
  int          first_cyc;
  int          done_cyc;
  int          done_cnt;

  task automatic pulse_start(input logic [4:0] b, input logic [5:0] l);
    @(negedge clk);
    bus.base_addr = b;
    bus.dump_len  = l;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the edge that samples start.
  task automatic run_dump(input logic [4:0] b, input logic [5:0] l, input int budget);
    words.delete(); lasts.delete(); addrs.delete();
    first_cyc = -1; done_cyc = -1; done_cnt = 0;
    pulse_start(b, l);
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.dout_valid && bus.dout_ready) begin
        words.push_back(bus.dout_data);
        lasts.push_back(bus.dout_last);
        addrs.push_back(bus.rf_addr);
        if (first_cyc < 0) first_cyc = c;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
  endtask

  vec_t vecs [7];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          extra;
    int          total;
    int          stall_done;
    int          dcnt;
    logic [31:0] ck;
    logic [4:0]  a;

    vecs[0] = '{5'd3,  6'd3,  3,  32'h0000_0011, 32'h0000_0033, 7};
    vecs[1] = '{5'd31, 6'd2,  2,  32'hDF1F_1F1F, 32'hC000_0000, 5};
    vecs[2] = '{5'd0,  6'd40, 32, 32'hC000_0000, 32'hDF1F_1F1F, 65};
    vecs[3] = '{5'd5,  6'd1,  1,  32'h0000_0033, 32'h0000_0033, 3};
    vecs[4] = '{5'd30, 6'd32, 32, 32'hDE1E_1E1E, 32'hDD1D_1D1D, 65};
    vecs[5] = '{5'd7,  6'd0,  0,  32'h0,         32'h0,         1};
    vecs[6] = '{5'd31, 6'd33, 32, 32'hDF1F_1F1F, 32'hDE1E_1E1E, 65};

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hC000_0000 + 32'(i) * 32'h0101_0101;
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    rf_mem[5] = 32'h33;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.dump_len = '0;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_last",  32'(bus.dout_last),  32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_done",  32'(bus.done),       32'd0);
    check("rst_addr",  32'(bus.rf_addr),    32'd0);
    check("rst_data",  bus.dout_data,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort while idle must leave the engine idle.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
`ifdef CHECKSUM_EN
      extra = (vecs[v].exp_n > 0) ? 1 : 0;
`else
      extra = 0;
`endif
      total = vecs[v].exp_n + extra;
      run_dump(vecs[v].base, vecs[v].len, 90);
      check($sformatf("v%0d_count", v), 32'(words.size()), 32'(total));
      check($sformatf("v%0d_done_cyc", v), 32'(done_cyc), 32'(vecs[v].exp_done_cyc + extra));
      check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
      if (vecs[v].exp_n > 0) begin
        check($sformatf("v%0d_latency", v), 32'(first_cyc), 32'd2);
        if (words.size() == total) begin
          check($sformatf("v%0d_first", v), words[0], vecs[v].exp_first);
          check($sformatf("v%0d_final", v), words[vecs[v].exp_n-1], vecs[v].exp_final);
          ck = '0;
          for (int k = 0; k < vecs[v].exp_n; k++) begin
            a = vecs[v].base + 5'(k);
            ck = ck ^ rf_mem[a];
            check($sformatf("v%0d_w%0d_data", v, k), words[k], rf_mem[a]);
            check($sformatf("v%0d_w%0d_addr", v, k), 32'(addrs[k]), 32'(a));
          end
          for (int k = 0; k < total; k++)
            check($sformatf("v%0d_w%0d_last", v, k), 32'(lasts[k]), 32'(k == total - 1));
`ifdef CHECKSUM_EN
          check($sformatf("v%0d_csum", v), words[total-1], ck);
`endif
        end
      end else begin
        check($sformatf("v%0d_no_valid", v), 32'(first_cyc), 32'hFFFF_FFFF);
      end
    end

    // Backpressure on the second word with a register-file write during the stall.
    words.delete(); stall_done = 0; dcnt = 0;
    pulse_start(5'd3, 6'd3);
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.done) dcnt++;
      if (bus.dout_valid && words.size() == 1 && stall_done == 0) begin
        stall_done = 1;
        bus.dout_ready = 1'b0;
        rf_mem[4] = 32'hDEAD_BEEF;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(bus.dout_valid), 32'd1);
          check("stall_data", bus.dout_data, 32'h22);
        end
        bus.dout_ready = 1'b1;
        rf_mem[4] = 32'h22;
      end
      if (bus.dout_valid && bus.dout_ready) words.push_back(bus.dout_data);
      if (dcnt > 0) break;
    end
`ifdef CHECKSUM_EN
    check("bp_count", 32'(words.size()), 32'd4);
`else
    check("bp_count", 32'(words.size()), 32'd3);
`endif
    if (words.size() >= 3) begin
      check("bp_w0", words[0], 32'h11);
      check("bp_w1", words[1], 32'h22);
      check("bp_w2", words[2], 32'h33);
    end
    check("bp_done", 32'(dcnt), 32'd1);

    // Abort while the second of four words is waiting.
    words.delete(); dcnt = 0;
    pulse_start(5'd10, 6'd4);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.dout_valid && words.size() == 1) break;
      if (bus.dout_valid && bus.dout_ready) words.push_back(bus.dout_data);
    end
    check("ab_pre_valid", 32'(bus.dout_valid), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("ab_valid", 32'(bus.dout_valid), 32'd0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    for (int c = 0; c < 6; c++) begin
      if (bus.done || bus.dout_valid) dcnt++;
      @(negedge clk);
    end
    check("ab_no_done", 32'(dcnt), 32'd0);

    // Asynchronous reset in the middle of a dump.
    pulse_start(5'd12, 6'd10);
    repeat (4) @(negedge clk);
    check("ar_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.dout_valid), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_addr", 32'(bus.rf_addr), 32'd0);
    check("ar_data", bus.dout_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Start while busy and start coincident with done are ignored.
    words.delete(); dcnt = 0; done_cyc = -1;
    pulse_start(5'd3, 6'd3);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      bus.start = 1'b0;
      if (bus.dout_valid && bus.dout_ready) words.push_back(bus.dout_data);
      if (bus.done) begin
        dcnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 3) begin
        bus.base_addr = 5'd20; bus.dump_len = 6'd5; bus.start = 1'b1;
      end
      if (bus.done) bus.start = 1'b1;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    bus.start = 1'b0;
`ifdef CHECKSUM_EN
    check("sb_count", 32'(words.size()), 32'd4);
`else
    check("sb_count", 32'(words.size()), 32'd3);
`endif
    if (words.size() >= 3) check("sb_w2", words[2], 32'h33);
    check("sb_done", 32'(dcnt), 32'd1);
    check("sb_idle", 32'(bus.busy), 32'd0);

`ifdef CHECKSUM_EN
    rf_mem[8] = 32'h0F; rf_mem[9] = 32'hF0; rf_mem[10] = 32'h01;
    run_dump(5'd8, 6'd3, 30);
    check("cs_count", 32'(words.size()), 32'd4);
    if (words.size() == 4) begin
      check("cs_word", words[3], 32'hFE);
      check("cs_last", 32'(lasts[3]), 32'd1);
      check("cs_reg_last", 32'({lasts[0], lasts[1], lasts[2]}), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
